// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency monitor: counts gray-coded foreign-domain counters over a fixed
// gate window, reports per-channel deltas over valid/ready and raises sticky range alarms.
module clk_freq_monitor #(
    parameter int NCH  = 4,
    parameter int CW   = 32,
    parameter int GATE = 1000000,
    parameter int GW   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [NCH*CW-1:0] cnt_gray,
    input  logic [NCH*CW-1:0] lim_lo,
    input  logic [NCH*CW-1:0] lim_hi,
    output logic [NCH*CW-1:0] freq_out,
    output logic              freq_valid,
    input  logic              freq_ready,
    output logic [NCH-1:0]    alarm,
    input  logic              alarm_clr,
    output logic              overrun,
    output logic [15:0]       win_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, MEASURE} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     gcnt, gcnt_nxt;
    logic              terminal;
    logic              report;

    logic [CW-1:0]     sync_p0 [NCH];
    logic [CW-1:0]     sync_p1 [NCH];
    logic [CW-1:0]     bin_p2  [NCH];
    logic [CW-1:0]     prev    [NCH];

    logic [NCH*CW-1:0] delta_flat;
    logic [NCH-1:0]    out_of_range;

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b = g;
        for (int i = CW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // p0/p1: two-flop synchroniser on the raw gray code; p2: decoded binary
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NCH; k++) begin
                sync_p0[k] <= '0;
                sync_p1[k] <= '0;
                bin_p2[k]  <= '0;
                prev[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                sync_p0[k] <= cnt_gray[k*CW +: CW];
                sync_p1[k] <= sync_p0[k];
                bin_p2[k]  <= gray2bin(sync_p1[k]);
                if (terminal) begin
                    prev[k] <= bin_p2[k];
                end
            end
        end
    end

    // Modulo subtraction absorbs wrap of the monitored counter within one window
    always_comb begin
        delta_flat   = '0;
        out_of_range = '0;
        for (int k = 0; k < NCH; k++) begin
            delta_flat[k*CW +: CW] = bin_p2[k] - prev[k];
            out_of_range[k] = (delta_flat[k*CW +: CW] < lim_lo[k*CW +: CW]) ||
                              (delta_flat[k*CW +: CW] > lim_hi[k*CW +: CW]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        terminal  = 1'b0;
        report    = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            gcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = PRIME;
                    gcnt_nxt  = '0;
                end
                PRIME, MEASURE: begin
                    if (gcnt == GW'(GATE - 1)) begin
                        terminal  = 1'b1;
                        report    = (state == MEASURE);
                        gcnt_nxt  = '0;
                        state_nxt = MEASURE;
                    end else begin
                        gcnt_nxt = gcnt + GW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    gcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Result stage: a new report always lands, even over an unconsumed one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
            alarm      <= '0;
            overrun    <= 1'b0;
            win_cnt    <= '0;
        end else begin
            if (!enable) begin
                freq_valid <= 1'b0;
            end else if (report) begin
                freq_out   <= delta_flat;
                freq_valid <= 1'b1;
                win_cnt    <= win_cnt + 16'd1;
            end else if (freq_valid && freq_ready) begin
                freq_valid <= 1'b0;
            end
            alarm   <= (alarm & ~{NCH{alarm_clr}}) | (report ? out_of_range : '0);
            overrun <= (overrun & ~alarm_clr) | (report && freq_valid && !freq_ready);
        end
    end

endmodule
